// File: rtl/alu_pkg.sv
// Shared types for the ALU command driver: opcode set, queued command word and the
// result byte returned for a rejected divide.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,  SUB  = 4'd1,  MUL  = 4'd2,  DIV  = 4'd3,
        ADDA = 4'd4,  MULA = 4'd5,  MAC  = 4'd6,  ROL  = 4'd7,
        ROR  = 4'd8,  AND  = 4'd9,  OR   = 4'd10, XOR  = 4'd11,
        NAND = 4'd12, EQ   = 4'd13, GT   = 4'd14, LT   = 4'd15
    } alu_op_e;

    typedef struct packed {
        alu_op_e    op;
        logic [7:0] a;
        logic [7:0] b;
    } alu_cmd_t;

    localparam logic [7:0] DIV_ERR_VAL = 8'hFF;

    // Ops that fold the ALU's own previous result back in; unsafe to leave selected.
    function automatic logic is_acc_op(input alu_op_e op);
        return (op == ADDA) || (op == MULA) || (op == MAC);
    endfunction

    function automatic logic is_div_zero(input alu_cmd_t cmd);
        return (cmd.op == DIV) && (cmd.b == 8'h00);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command queue: write visible at head one cycle after push, read is
// combinational from head. Push is dropped while full even if a pop occurs the same edge.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  alu_cmd_t wdata_i,
    input  logic     pop_i,
    output alu_cmd_t rdata_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    alu_cmd_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push_en;
    logic            pop_en;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// Serialises queued ALU commands: issue, wait ALU_LATENCY edges, return result over valid/ready.
// Result is held until accepted; cmd_ready drops only when the queue is full.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] rsp_op,
    output logic       rsp_err,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_sel,
    input  logic [7:0] alu_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int            LW       = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [LW-1:0] LAT_LOAD = LW'(ALU_LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] lat_q, lat_d;
    alu_op_e       op_q, op_d;
    logic [7:0]    alu_a_q, alu_a_d;
    logic [7:0]    alu_b_q, alu_b_d;
    logic [3:0]    alu_sel_q, alu_sel_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic [3:0]    rsp_op_q, rsp_op_d;
    logic          rsp_err_q, rsp_err_d;

    alu_cmd_t      cmd_word;
    alu_cmd_t      head_cmd;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    assign cmd_word = '{op: alu_op_e'(cmd_op), a: cmd_a, b: cmd_b};

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid),
        .wdata_i (cmd_word),
        .pop_i   (pop),
        .rdata_o (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign cmd_ready = !fifo_full;
    assign pop       = !fifo_empty &&
                       ((state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready));

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        op_d       = op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        rsp_data_d = rsp_data_q;
        rsp_op_d   = rsp_op_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (pop) begin
                    op_d = head_cmd.op;
                    // A zero divisor never reaches the ALU; answer it directly.
                    if (is_div_zero(head_cmd)) begin
                        rsp_data_d = DIV_ERR_VAL;
                        rsp_op_d   = DIV;
                        rsp_err_d  = 1'b1;
                        state_d    = S_RESP;
                    end else begin
                        alu_a_d   = head_cmd.a;
                        alu_b_d   = head_cmd.b;
                        alu_sel_d = head_cmd.op;
                        state_d   = S_ISSUE;
                    end
                end else if ((state_q == S_RESP) && rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                lat_d   = LAT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    rsp_data_d = alu_out;
                    rsp_op_d   = op_q;
                    rsp_err_d  = 1'b0;
                    // Park on ADD so the free-running ALU stops folding into its accumulator.
                    if (is_acc_op(op_q)) begin
                        alu_sel_d = ADD;
                    end
                    state_d = S_RESP;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lat_q      <= '0;
            op_q       <= ADD;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            rsp_data_q <= '0;
            rsp_op_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            op_q       <= op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_op_q   <= rsp_op_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_op    = rsp_op_q;
    assign rsp_err   = rsp_err_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver driving a behavioural registered 8-bit ALU.
`timescale 1ns/1ps
module tb_alu_cmd_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_op;
    logic       rsp_err;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;

    int n_checks = 0;
    int n_fail   = 0;
    int div_zero_seen = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(
        .FIFO_DEPTH  (4),
        .ALU_LATENCY (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_op    (rsp_op),
        .rsp_err   (rsp_err),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out)
    );

    // Registered ALU: plain ops recompute every edge; accumulate ops apply once per
    // newly presented word. The accumulator is not touched by the ADD parked after them.
    logic [7:0]  acc_q  = 8'h00;
    logic [7:0]  out_q  = 8'h00;
    logic [19:0] last_q = 20'h0;
    logic [7:0]  alu_res;
    logic        alu_new;

    function automatic logic [7:0] alu_f(input logic [3:0] sel, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] acc);
        logic [15:0] p;
        logic [15:0] q;
        p = a * b;
        q = acc * a;
        case (sel)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return p[7:0];
            4'h3: return (b == 8'h00) ? 8'hFF : a / b;
            4'h4: return acc + a;
            4'h5: return q[7:0];
            4'h6: return acc + p[7:0];
            4'h7: return {a[6:0], a[7]};
            4'h8: return {a[0], a[7:1]};
            4'h9: return a & b;
            4'hA: return a | b;
            4'hB: return a ^ b;
            4'hC: return ~(a & b);
            4'hD: return {7'd0, a == b};
            4'hE: return {7'd0, a > b};
            default: return {7'd0, a < b};
        endcase
    endfunction

    always_comb begin
        alu_new = ({alu_sel, alu_a, alu_b} != last_q);
        alu_res = alu_f(alu_sel, alu_a, alu_b, acc_q);
    end

    always @(posedge clk) begin
        last_q <= {alu_sel, alu_a, alu_b};
        if (alu_sel inside {4'h4, 4'h5, 4'h6}) begin
            if (alu_new) begin
                acc_q <= alu_res;
                out_q <= alu_res;
            end
        end else begin
            out_q <= alu_res;
            if (alu_new && !(last_q[19:16] inside {4'h4, 4'h5, 4'h6})) begin
                acc_q <= alu_res;
            end
        end
    end

    assign alu_out = out_q;

    always @(negedge clk) begin
        if (rst_n && (alu_sel == 4'h3) && (alu_b == 8'h00)) begin
            div_zero_seen <= div_zero_seen + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int waited = 0;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) begin
            check("push_timeout", 32'(cmd_ready), 32'd1);
        end else begin
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [7:0] data, input logic [3:0] op,
                              input logic err, input logic [3:0] sel, input int stall);
        int waited = 0;
        while (!rsp_valid && waited < 40) begin
            tick();
            waited++;
        end
        repeat (stall) tick();
        check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        check({tag, "_dat"}, 32'(rsp_data), 32'(data));
        check({tag, "_op"},  32'(rsp_op),   32'(op));
        check({tag, "_err"}, 32'(rsp_err),  32'(err));
        check({tag, "_sel"}, 32'(alu_sel),  32'(sel));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    logic [3:0] t2_op  [5] = '{4'h1, 4'hB, 4'h9, 4'h2, 4'hA};
    logic [7:0] t2_a   [5] = '{8'h50, 8'hF0, 8'hF0, 8'h07, 8'h81};
    logic [7:0] t2_b   [5] = '{8'h20, 8'h3C, 8'h3C, 8'h06, 8'h02};
    logic [7:0] t2_exp [5] = '{8'h30, 8'hCC, 8'h30, 8'h2A, 8'h83};

    logic [3:0] t6_op  [5] = '{4'h1, 4'h0, 4'hB, 4'h9, 4'hA};
    logic [7:0] t6_exp [5] = '{8'h0F, 8'h40, 8'hF0, 8'h0C, 8'h33};

    initial begin
        int lat;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        rsp_ready = 1'b0;
        repeat (2) tick();

        check("rst_vld",   32'(rsp_valid), 32'd0);
        check("rst_dat",   32'(rsp_data),  32'd0);
        check("rst_op",    32'(rsp_op),    32'd0);
        check("rst_err",   32'(rsp_err),   32'd0);
        check("rst_alu_a", 32'(alu_a),     32'd0);
        check("rst_alu_b", 32'(alu_b),     32'd0);
        check("rst_sel",   32'(alu_sel),   32'd0);
        check("rst_rdy",   32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Single ADD: result three edges after the push edge (pop, issue, capture).
        rsp_ready = 1'b1;
        push_cmd(4'h0, 8'h12, 8'h34);
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("t1_lat",   32'(lat),       32'd3);
        check("t1_dat",   32'(rsp_data),  32'h46);
        check("t1_op",    32'(rsp_op),    32'h0);
        check("t1_err",   32'(rsp_err),   32'd0);
        check("t1_alu_a", 32'(alu_a),     32'h12);
        tick();
        check("t1_done",  32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // Five back-to-back pushes with the consumer stalled: four queued plus one in flight.
        for (int i = 0; i < 5; i++) begin
            push_cmd(t2_op[i], t2_a[i], t2_b[i]);
        end
        check("t2_full", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            expect_rsp($sformatf("t2_%0d", i), t2_exp[i], t2_op[i], 1'b0, t2_op[i], 0);
        end

        // Push and response pop on the same edge with three queued.
        push_cmd(4'h0, 8'h10, 8'h01);
        push_cmd(4'h1, 8'h10, 8'h01);
        push_cmd(4'h0, 8'h20, 8'h20);
        push_cmd(4'hB, 8'hFF, 8'h0F);
        check("t6_vld", 32'(rsp_valid), 32'd1);
        check("t6_a",   32'(rsp_data),  32'h11);
        check("t6_rdy", 32'(cmd_ready), 32'd1);
        cmd_op    = 4'h9;
        cmd_a     = 8'h3C;
        cmd_b     = 8'h0F;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check("t6_cnt3", 32'(cmd_ready), 32'd1);
        push_cmd(4'hA, 8'h30, 8'h03);
        check("t6_cnt4", 32'(cmd_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            expect_rsp($sformatf("t6_%0d", i), t6_exp[i], t6_op[i], 1'b0, t6_op[i], 0);
        end

        // Divide by zero answered without touching the ALU; a legal divide follows.
        push_cmd(4'h3, 8'h20, 8'h00);
        push_cmd(4'h3, 8'h20, 8'h04);
        check("t3_hold_a", 32'(alu_a), 32'h30);
        check("t3_hold_b", 32'(alu_b), 32'h03);
        expect_rsp("t3_dz",  8'hFF, 4'h3, 1'b1, 4'hA, 0);
        expect_rsp("t3_div", 8'h08, 4'h3, 1'b0, 4'h3, 0);
        check("t3_never", 32'(div_zero_seen), 32'd0);

        // Accumulate chain with a long consumer stall after each result.
        push_cmd(4'h0, 8'h03, 8'h04);
        push_cmd(4'h6, 8'h02, 8'h05);
        push_cmd(4'h4, 8'h01, 8'h99);
        expect_rsp("t4_add",  8'h07, 4'h0, 1'b0, 4'h0, 10);
        expect_rsp("t4_mac",  8'h11, 4'h6, 1'b0, 4'h0, 10);
        expect_rsp("t4_adda", 8'h12, 4'h4, 1'b0, 4'h0, 10);

        // Reset while waiting on the ALU with one more command queued.
        push_cmd(4'hB, 8'h05, 8'h03);
        push_cmd(4'hA, 8'h01, 8'h02);
        tick();
        rst_n = 1'b0;
        tick();
        check("t5_vld", 32'(rsp_valid), 32'd0);
        check("t5_sel", 32'(alu_sel),   32'd0);
        check("t5_a",   32'(alu_a),     32'd0);
        check("t5_rdy", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        repeat (6) tick();
        check("t5_idle_vld", 32'(rsp_valid), 32'd0);
        check("t5_idle_sel", 32'(alu_sel),   32'd0);
        check("t5_idle_a",   32'(alu_a),     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
